// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer path: frame geometry, pixel
// field layout and the scheduler FSM encoding. The VGA controller pulls
// FB_FRAME_WORDS from here so both sides agree on the frame size.
package fb_pkg;

    localparam int FB_FRAME_WORDS = 30720;
    localparam int FB_ADDR_W      = 16;
    localparam int FB_PXL_W       = 12;

    // Pixel word layout {R[3:0], G[3:0], B[3:0]}
    localparam int PXL_R_HI = 11;
    localparam int PXL_R_LO = 8;
    localparam int PXL_G_HI = 7;
    localparam int PXL_G_LO = 4;
    localparam int PXL_B_HI = 3;
    localparam int PXL_B_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SOF   = 2'd1,
        ST_FILL_FIRST = 2'd2,
        ST_RUN        = 2'd3
    } fb_state_e;

    // Assemble a stored pixel word from its colour fields.
    function automatic logic [FB_PXL_W-1:0] fb_pixel(input logic [3:0] r,
                                                     input logic [3:0] g,
                                                     input logic [3:0] b);
        logic [FB_PXL_W-1:0] p;
        p = {FB_PXL_W{1'b0}};
        p[PXL_R_HI:PXL_R_LO] = r;
        p[PXL_G_HI:PXL_G_LO] = g;
        p[PXL_B_HI:PXL_B_LO] = b;
        return p;
    endfunction

endpackage

// File: rtl/fb_write_ctrl.sv
// Capture-side write controller: frame address counter, write-active flag,
// short/overflow detection and the registered BRAM write port.
// A start (SOF) in the same cycle as a valid pixel makes that pixel address 0.
// FRAME_WORDS must not exceed 2**ADDR_W.
module fb_write_ctrl #(
    parameter int FRAME_WORDS = 30720,
    parameter int ADDR_W      = 16,
    parameter int PXL_W       = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              quiet_i,
    input  logic              start_i,
    input  logic              valid_i,
    input  logic [PXL_W-1:0]  pxl_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [PXL_W-1:0]  wr_data_o,
    output logic              frame_done_o,
    output logic              full_o,
    output logic              short_err_o,
    output logic              ovf_err_o
);

    // One extra bit so the count FRAME_WORDS itself is representable.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              wr_active_q, wr_active_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PXL_W-1:0]  wr_data_q, wr_data_d;
    logic              short_q, short_d;
    logic              ovf_q, ovf_d;

    logic [CNT_W-1:0]  eff_cnt_s;
    logic              eff_active_s;
    logic              room_s;
    logic              accept_s;

    // Effective frame position this cycle, with a concurrent SOF taking effect first.
    always_comb begin
        eff_cnt_s    = start_i ? {CNT_W{1'b0}} : wr_cnt_q;
        eff_active_s = start_i | wr_active_q;
        room_s       = eff_active_s && (eff_cnt_s < FULL_CNT);
        accept_s     = valid_i && !quiet_i && room_s;
        frame_done_o = accept_s && (eff_cnt_s == LAST_CNT);
        full_o       = (wr_cnt_q == FULL_CNT);
    end

    // Next-state for the counter, write port and sticky error flags.
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        wr_active_d = wr_active_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        short_d     = short_q;
        ovf_d       = ovf_q;

        if (clear_i) begin
            wr_cnt_d    = {CNT_W{1'b0}};
            wr_active_d = 1'b0;
            wr_addr_d   = {ADDR_W{1'b0}};
            wr_data_d   = {PXL_W{1'b0}};
        end else if (accept_s) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = eff_cnt_s[ADDR_W-1:0];
            wr_data_d   = pxl_i;
            wr_cnt_d    = eff_cnt_s + ONE_CNT;
            wr_active_d = !frame_done_o;
        end else if (start_i) begin
            wr_cnt_d    = {CNT_W{1'b0}};
            wr_active_d = 1'b1;
        end else begin
            wr_cnt_d    = wr_cnt_q;
            wr_active_d = wr_active_q;
        end

        if (!clear_i && start_i && wr_active_q && (wr_cnt_q < FULL_CNT)) begin
            short_d = 1'b1;
        end else begin
            short_d = short_q;
        end

        if (valid_i && !quiet_i && !room_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Register bank with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q    <= {CNT_W{1'b0}};
            wr_active_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= {ADDR_W{1'b0}};
            wr_data_q   <= {PXL_W{1'b0}};
            short_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_active_q <= wr_active_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            short_q     <= short_d;
            ovf_q       <= ovf_d;
        end
    end

    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign short_err_o = short_q;
    assign ovf_err_o   = ovf_q;

endmodule

// File: rtl/fb_bank_scheduler.sv
// Ping-pong frame-buffer scheduler. Capture writes the back bank, VGA scans
// the front bank; banks swap only at a VGA end-of-frame when a complete back
// frame is waiting, and VGA timing stays off until the first frame is stored.
module fb_bank_scheduler
    import fb_pkg::*;
#(
    parameter int FRAME_WORDS = FB_FRAME_WORDS,
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int PXL_W       = FB_PXL_W
) (
    input  logic              CLK_25_I,
    input  logic              RST_I,
    input  logic              ENABLE_I,
    input  logic              CAP_SOF_I,
    input  logic              CAP_VALID_I,
    input  logic [PXL_W-1:0]  CAP_PXL_I,
    input  logic              VGA_EOF_I,
    output logic              WR_EN_O,
    output logic              WR_BANK_O,
    output logic [ADDR_W-1:0] WR_ADDR_O,
    output logic [PXL_W-1:0]  WR_DATA_O,
    output logic              RD_BANK_O,
    output logic              VGA_EN_O,
    output logic              DROP_O,
    output logic              SHORT_ERR_O,
    output logic              OVF_ERR_O
);

    fb_state_e state_q, state_d;
    logic      rd_bank_q, rd_bank_d;
    logic      wr_bank_q, wr_bank_d;
    logic      vga_en_q, vga_en_d;
    logic      back_ready_q, back_ready_d;
    logic      drop_q, drop_d;

    logic      wc_clear_s;
    logic      wc_quiet_s;
    logic      wc_start_s;
    logic      wc_frame_done_s;
    logic      wc_full_s;

    fb_write_ctrl #(
        .FRAME_WORDS (FRAME_WORDS),
        .ADDR_W      (ADDR_W),
        .PXL_W       (PXL_W)
    ) u_write_ctrl (
        .clk_i        (CLK_25_I),
        .rst_i        (RST_I),
        .clear_i      (wc_clear_s),
        .quiet_i      (wc_quiet_s),
        .start_i      (wc_start_s),
        .valid_i      (CAP_VALID_I),
        .pxl_i        (CAP_PXL_I),
        .wr_en_o      (WR_EN_O),
        .wr_addr_o    (WR_ADDR_O),
        .wr_data_o    (WR_DATA_O),
        .frame_done_o (wc_frame_done_s),
        .full_o       (wc_full_s),
        .short_err_o  (SHORT_ERR_O),
        .ovf_err_o    (OVF_ERR_O)
    );

    // Writer control: idle/disabled clears it, pixels before a first SOF are ignored silently.
    always_comb begin
        wc_clear_s = !ENABLE_I || (state_q == ST_IDLE);
        wc_quiet_s = wc_clear_s || ((state_q == ST_WAIT_SOF) && !CAP_SOF_I);
        wc_start_s = ENABLE_I && CAP_SOF_I && (state_q != ST_IDLE);
    end

    // FSM next state, bank select, back-frame bookkeeping and drop pulse.
    always_comb begin
        state_d      = state_q;
        rd_bank_d    = rd_bank_q;
        wr_bank_d    = wr_bank_q;
        vga_en_d     = vga_en_q;
        back_ready_d = back_ready_q;
        drop_d       = 1'b0;

        if (!ENABLE_I) begin
            state_d      = ST_IDLE;
            rd_bank_d    = 1'b1;
            wr_bank_d    = 1'b0;
            vga_en_d     = 1'b0;
            back_ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_WAIT_SOF;
                    rd_bank_d    = 1'b1;
                    wr_bank_d    = 1'b0;
                    vga_en_d     = 1'b0;
                    back_ready_d = 1'b0;
                end
                ST_WAIT_SOF: begin
                    if (CAP_SOF_I) begin
                        state_d = ST_FILL_FIRST;
                    end else begin
                        state_d = ST_WAIT_SOF;
                    end
                end
                ST_FILL_FIRST: begin
                    // First frame is complete: show it and start the display.
                    if (wc_full_s) begin
                        rd_bank_d = ~rd_bank_q;
                        wr_bank_d = ~wr_bank_q;
                        vga_en_d  = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        state_d   = ST_FILL_FIRST;
                    end
                end
                ST_RUN: begin
                    // Swap beats a concurrent SOF; an unswapped ready frame is overwritten.
                    if (VGA_EOF_I && back_ready_q) begin
                        rd_bank_d    = ~rd_bank_q;
                        wr_bank_d    = ~wr_bank_q;
                        back_ready_d = 1'b0;
                    end else if (CAP_SOF_I && back_ready_q) begin
                        back_ready_d = 1'b0;
                        drop_d       = 1'b1;
                    end else if (wc_frame_done_s) begin
                        back_ready_d = 1'b1;
                    end else begin
                        back_ready_d = back_ready_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK_25_I) begin
        if (RST_I) begin
            state_q      <= ST_IDLE;
            rd_bank_q    <= 1'b1;
            wr_bank_q    <= 1'b0;
            vga_en_q     <= 1'b0;
            back_ready_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_bank_q    <= rd_bank_d;
            wr_bank_q    <= wr_bank_d;
            vga_en_q     <= vga_en_d;
            back_ready_q <= back_ready_d;
            drop_q       <= drop_d;
        end
    end

    assign RD_BANK_O = rd_bank_q;
    assign WR_BANK_O = wr_bank_q;
    assign VGA_EN_O  = vga_en_q;
    assign DROP_O    = drop_q;

endmodule

// File: tb/tb_fb_bank_scheduler.sv
// Directed bench for fb_bank_scheduler with a reduced frame size. A frame-level
// model predicts the outputs after every clock edge; a compare process checks
// them on the falling edge, and literal spot checks pin the model at key points.
module tb_fb_bank_scheduler;
    import fb_pkg::*;

    localparam int FW = 16;
    localparam int AW = 16;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          sof = 1'b0;
    logic          valid = 1'b0;
    logic          eof = 1'b0;
    logic [PW-1:0] pxl = '0;

    logic          WR_EN_O, WR_BANK_O, RD_BANK_O, VGA_EN_O, DROP_O, SHORT_ERR_O, OVF_ERR_O;
    logic [AW-1:0] WR_ADDR_O;
    logic [PW-1:0] WR_DATA_O;

    always #20 clk = ~clk;

    fb_bank_scheduler #(.FRAME_WORDS(FW), .ADDR_W(AW), .PXL_W(PW)) dut (
        .CLK_25_I(clk), .RST_I(rst), .ENABLE_I(en), .CAP_SOF_I(sof),
        .CAP_VALID_I(valid), .CAP_PXL_I(pxl), .VGA_EOF_I(eof),
        .WR_EN_O(WR_EN_O), .WR_BANK_O(WR_BANK_O), .WR_ADDR_O(WR_ADDR_O),
        .WR_DATA_O(WR_DATA_O), .RD_BANK_O(RD_BANK_O), .VGA_EN_O(VGA_EN_O),
        .DROP_O(DROP_O), .SHORT_ERR_O(SHORT_ERR_O), .OVF_ERR_O(OVF_ERR_O)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int drop_seen = 0;

    // Model: mode 0 idle, 1 waiting for first SOF, 2 filling first frame, 3 running.
    int          m_mode = 0;
    bit          m_writing = 1'b0;
    int          m_pos = 0;
    bit          m_ready = 1'b0;
    bit          m_disp = 1'b1;
    bit          m_short = 1'b0;
    bit          m_ovf = 1'b0;
    bit          e_wr_en = 1'b0;
    int          e_addr = 0;
    logic [PW-1:0] e_data = '0;
    bit          e_drop = 1'b0;
    bit          e_vga = 1'b0;

    function automatic logic [PW-1:0] px(input int f, input int i);
        return fb_pixel(4'(f), 4'(i), 4'(i + 3));
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        #1;
        n_vec++;
        cmp(name, act, exp);
    endtask

    // Advance the model by one clock edge using the inputs that edge samples.
    task automatic model_step();
        int start_mode;
        if (rst) begin
            m_mode = 0; m_writing = 0; m_pos = 0; m_ready = 0; m_disp = 1;
            m_short = 0; m_ovf = 0;
            e_wr_en = 0; e_addr = 0; e_data = '0; e_drop = 0;
        end else if (!en) begin
            m_mode = 0; m_writing = 0; m_pos = 0; m_ready = 0; m_disp = 1;
            e_wr_en = 0; e_addr = 0; e_data = '0; e_drop = 0;
        end else begin
            start_mode = m_mode;
            e_wr_en = 0;
            e_drop = 0;
            if (start_mode == 0) begin
                m_mode = 1;
            end else if (start_mode == 1) begin
                if (sof) begin
                    m_mode = 2; m_writing = 1; m_pos = 0;
                end
            end else begin
                if (start_mode == 2 && !m_writing && m_pos == FW) begin
                    m_disp = !m_disp; m_mode = 3;
                end
                if (start_mode == 3) begin
                    if (eof && m_ready) begin
                        m_disp = !m_disp; m_ready = 0;
                    end else if (sof && m_ready) begin
                        m_ready = 0; e_drop = 1;
                    end
                end
                if (sof) begin
                    if (m_writing) m_short = 1;
                    m_writing = 1; m_pos = 0;
                end
            end
            if (valid && (start_mode >= 2 || (start_mode == 1 && sof))) begin
                if (m_writing && m_pos < FW) begin
                    e_wr_en = 1; e_addr = m_pos; e_data = pxl;
                    m_pos++;
                    if (m_pos == FW) begin
                        m_writing = 0;
                        if (start_mode == 3) m_ready = 1;
                    end
                end else begin
                    m_ovf = 1;
                end
            end
        end
        e_vga = (m_mode == 3);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            cmp("wr_en", WR_EN_O, e_wr_en);
            if (e_wr_en) begin
                cmp("wr_addr", WR_ADDR_O, e_addr);
                cmp("wr_data", WR_DATA_O, e_data);
            end
            cmp("rd_bank", RD_BANK_O, m_disp);
            cmp("wr_bank", WR_BANK_O, !m_disp);
            cmp("bank_invariant", WR_BANK_O ^ RD_BANK_O, 1);
            cmp("vga_en", VGA_EN_O, e_vga);
            cmp("drop", DROP_O, e_drop);
            cmp("short_err", SHORT_ERR_O, m_short);
            cmp("ovf_err", OVF_ERR_O, m_ovf);
            if (DROP_O) drop_seen++;
        end
    end

    task automatic cyc(input bit r, input bit e, input bit s, input bit v, input bit f, input logic [PW-1:0] p);
        rst = r; en = e; sof = s; valid = v; eof = f; pxl = p;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic pixels(input int f, input int first, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, px(f, first + i));
    endtask

    initial begin
        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk_en = 1'b1;
        lit("rst_wr_en", WR_EN_O, 0);
        lit("rst_wr_addr", WR_ADDR_O, 0);
        lit("rst_wr_data", WR_DATA_O, 0);
        lit("rst_wr_bank", WR_BANK_O, 0);
        lit("rst_rd_bank", RD_BANK_O, 1);
        lit("rst_vga_en", VGA_EN_O, 0);
        lit("rst_errs", {SHORT_ERR_O, OVF_ERR_O, DROP_O}, 0);

        // First frame; pixels before SOF are silently ignored
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, px(0, 0));
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, px(0, 1));
        lit("pre_sof_ovf", OVF_ERR_O, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        pixels(1, 0, 1);
        lit("first_addr", WR_ADDR_O, 0);
        lit("first_en", WR_EN_O, 1);
        lit("first_data", WR_DATA_O, 12'h103);
        pixels(1, 1, FW - 1);
        lit("last_addr", WR_ADDR_O, FW - 1);
        lit("last_bank", WR_BANK_O, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        lit("fill_rd", RD_BANK_O, 0);
        lit("fill_wr", WR_BANK_O, 1);
        lit("fill_vga", VGA_EN_O, 1);

        // Second frame then swap; a second EOF with nothing new does not swap
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        pixels(2, 0, FW);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        lit("ready_no_swap", RD_BANK_O, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        lit("swap_rd", RD_BANK_O, 1);
        lit("swap_wr", WR_BANK_O, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        lit("no_reswap", RD_BANK_O, 1);

        // Two frames without EOF: one drop, same bank rewritten
        drop_seen = 0;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        pixels(3, 0, FW);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        lit("drop_pulse", DROP_O, 1);
        pixels(4, 0, FW);
        lit("rewrite_bank", WR_BANK_O, 0);
        lit("drop_count", drop_seen, 1);

        // Short frame
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        pixels(5, 0, 10);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        lit("short_err", SHORT_ERR_O, 1);
        pixels(6, 0, 1);
        lit("short_restart_addr", WR_ADDR_O, 0);
        lit("short_restart_bank", WR_BANK_O, 1);
        pixels(6, 1, FW - 1);

        // Overflow: pixels after a full frame
        pixels(7, 0, 5);
        lit("ovf_no_write", WR_EN_O, 0);
        lit("ovf_err", OVF_ERR_O, 1);

        // EOF + SOF + pixel together with a ready frame: swap wins
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, px(8, 0));
        lit("sim_drop", DROP_O, 0);
        lit("sim_rd", RD_BANK_O, 1);
        lit("sim_wr_bank", WR_BANK_O, 0);
        lit("sim_addr", WR_ADDR_O, 0);
        pixels(8, 1, 3);

        // Reset mid-frame with a pixel present
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, px(9, 0));
        lit("midrst_wr_en", WR_EN_O, 0);
        lit("midrst_rd", RD_BANK_O, 1);
        lit("midrst_errs", {SHORT_ERR_O, OVF_ERR_O, VGA_EN_O}, 0);

        // Disable keeps error flags
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        pixels(10, 0, 5);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, px(10, 5));
        lit("dis_short_kept", SHORT_ERR_O, 1);
        lit("dis_wr_en", WR_EN_O, 0);
        lit("dis_vga", VGA_EN_O, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, px(10, 6));

        // Restart from idle through a full first frame
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, px(11, 0));
        pixels(11, 1, FW - 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        lit("restart_vga", VGA_EN_O, 1);
        lit("restart_rd", RD_BANK_O, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
